// File: rtl/soc_imem_fetch_if.sv
// Signal bundle for soc_imem_fetch: instruction-RAM request port plus the core-side
// redirect input and valid/ready instruction stream. master = fetch unit, slave = its environment.
interface soc_imem_fetch_if;
  logic [31:2] o_mem_addr;
  logic        o_mem_rd_en;
  logic [3:0]  o_mem_be;
  logic        o_mem_wr_en;
  logic [31:0] o_mem_wr_data;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_busy;
  logic        i_mem_ack;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;

  modport master (
    output o_mem_addr, o_mem_rd_en, o_mem_be, o_mem_wr_en, o_mem_wr_data,
           o_instr_valid, o_instr, o_instr_pc,
    input  i_mem_rd_data, i_mem_busy, i_mem_ack, i_redirect, i_redirect_pc, i_instr_ready
  );

  modport slave (
    input  o_mem_addr, o_mem_rd_en, o_mem_be, o_mem_wr_en, o_mem_wr_data,
           o_instr_valid, o_instr, o_instr_pc,
    output i_mem_rd_data, i_mem_busy, i_mem_ack, i_redirect, i_redirect_pc, i_instr_ready
  );
endinterface

// File: rtl/soc_imem_fetch.sv
// Instruction prefetch: sequential word reads with one request in flight, a 2**p_fifo_pw2 word
// FIFO toward the core, and redirect flush. Macro IMEM_FETCH_BYPASS_EN forwards acks past an empty FIFO.
module soc_imem_fetch #(
  parameter logic [31:0] p_boot_addr = 32'hf0000000,
  parameter int unsigned p_fifo_pw2  = 1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  soc_imem_fetch_if.master io_bus
);
  localparam int unsigned    lp_depth   = 1 << p_fifo_pw2;
  localparam int unsigned    lp_cw      = p_fifo_pw2 + 1;
  localparam logic [lp_cw:0] lp_depth_w = (lp_cw + 1)'(lp_depth);

  typedef enum logic {ST_FETCH = 1'b0, ST_DROP = 1'b1} state_t;

  state_t                r_state, w_state_next;
  logic [31:2]           r_pc;
  logic [31:2]           r_tag;
  logic                  r_out;
  logic [lp_cw-1:0]      r_count;
  logic [p_fifo_pw2-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]           r_fifo_data [lp_depth];
  logic [31:2]           r_fifo_pc   [lp_depth];

  logic           w_issue, w_accept, w_ack_ok, w_empty;
  logic           w_push, w_pop, w_fifo_pop;
  logic [lp_cw:0] w_credit;
  logic           w_unused;

  assign w_empty    = (r_count == '0);
  assign w_credit   = {1'b0, r_count} + (lp_cw + 1)'(r_out) - (lp_cw + 1)'(w_pop);
  assign w_accept   = w_issue && !io_bus.i_mem_busy;
  assign w_pop      = io_bus.o_instr_valid && io_bus.i_instr_ready;
  assign w_fifo_pop = w_pop && !w_empty;
  assign w_unused   = ^io_bus.i_redirect_pc[1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_FETCH;
    else          r_state <= w_state_next;
  end

  // A redirect with a read in flight and no ack this cycle must swallow that later ack.
  always_comb begin
    // NOTE: default first, so every path assigns w_state_next and no latch is inferred.
    w_state_next = ST_FETCH;
    if (r_out && !io_bus.i_mem_ack && (io_bus.i_redirect || r_state == ST_DROP))
      w_state_next = ST_DROP;
  end

  // Credit counts buffered words plus the one in flight, net of this cycle's pop.
  always_comb begin
    w_ack_ok = io_bus.i_mem_ack && r_out && (r_state == ST_FETCH) && !io_bus.i_redirect;
    w_issue  = i_rst_n && (r_state == ST_FETCH) && !io_bus.i_redirect &&
               (!r_out || io_bus.i_mem_ack) && (w_credit < lp_depth_w);
  end

  assign io_bus.o_mem_rd_en   = w_issue;
  assign io_bus.o_mem_addr    = r_pc;
  assign io_bus.o_mem_be      = 4'hf;
  assign io_bus.o_mem_wr_en   = 1'b0;
  assign io_bus.o_mem_wr_data = '0;

`ifdef IMEM_FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_empty && w_ack_ok;
  assign w_push   = w_ack_ok && !(w_bypass && io_bus.i_instr_ready);
  assign io_bus.o_instr_valid = i_rst_n && (!w_empty || w_bypass);
  assign io_bus.o_instr    = !i_rst_n ? '0 :
                             !w_empty ? r_fifo_data[r_rd_ptr] :
                             w_bypass ? io_bus.i_mem_rd_data : '0;
  assign io_bus.o_instr_pc = !i_rst_n ? '0 :
                             !w_empty ? {r_fifo_pc[r_rd_ptr], 2'b00} :
                             w_bypass ? {r_tag, 2'b00} : '0;
`else
  assign w_push = w_ack_ok;
  assign io_bus.o_instr_valid = !w_empty;
  assign io_bus.o_instr    = w_empty ? '0 : r_fifo_data[r_rd_ptr];
  assign io_bus.o_instr_pc = w_empty ? '0 : {r_fifo_pc[r_rd_ptr], 2'b00};
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: <= throughout, so every register here samples pre-edge values regardless of order.
    if (!i_rst_n) begin
      r_pc     <= p_boot_addr[31:2];
      r_tag    <= '0;
      r_out    <= 1'b0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (io_bus.i_redirect) r_pc <= io_bus.i_redirect_pc[31:2];
      else if (w_accept)     r_pc <= r_pc + 30'd1;
      if (w_accept) r_tag <= r_pc;
      r_out <= w_accept || (r_out && !io_bus.i_mem_ack);
      if (io_bus.i_redirect) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push)     r_wr_ptr <= r_wr_ptr + p_fifo_pw2'(1);
        if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + p_fifo_pw2'(1);
        r_count <= r_count + lp_cw'(w_push) - lp_cw'(w_fifo_pop);
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; r_count alone says which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= io_bus.i_mem_rd_data;
      r_fifo_pc[r_wr_ptr]   <= r_tag;
    end
  end
endmodule

// File: tb/tb_soc_imem_fetch.sv
// Scoreboard bench for soc_imem_fetch: a behavioural RAM answers reads, the expected core stream
// is the sequential word list from the last start PC, and a monitor checks every handshake.
`timescale 1ns/1ps
module tb_soc_imem_fetch;
  localparam logic [31:0] boot  = 32'hf0000000;
  localparam int unsigned pw2   = 1;
  localparam int          depth = 1 << pw2;
`ifdef IMEM_FETCH_BYPASS_EN
  localparam logic byp = 1'b1;
`else
  localparam logic byp = 1'b0;
`endif

  typedef struct packed {logic [31:0] pc; logic [31:0] data;} item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soc_imem_fetch_if bus();
  soc_imem_fetch #(.p_boot_addr(boot), .p_fifo_pw2(pw2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus.master));

  int checks = 0;
  int errors = 0;
  item_t exp_q[$];
  logic [31:0] exp_tail, exp_req_pc;
  bit first_ack_chk, drv_ack_dead;
  bit ram_pending, ram_drop;
  logic [31:0] ram_addr;
  int unsigned ram_lat;
  int unsigned lat_min, lat_max, busy_pct, ready_pct, redir_pm;
  bit spurious_en;
  logic mon_acc, mon_ack, mon_redir;
  logic [31:2] mon_addr;
  int pop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h0badc0de;
  endfunction

  task automatic refill();
    item_t it;
    while (exp_q.size() < 16) begin
      it.pc = exp_tail;
      it.data = mem_word(exp_tail);
      exp_q.push_back(it);
      exp_tail += 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_tail = {pc[31:2], 2'b00};
    exp_req_pc = exp_tail;
    first_ack_chk = 1'b1;
    refill();
  endtask

  // Monitor: samples mid-cycle, checks requests and every delivered word.
  bit prev_hold, prev_redir;
  logic [31:2] prev_addr;
  always @(negedge clk) begin
    item_t it;
    mon_acc = 1'b0; mon_ack = 1'b0; mon_redir = 1'b0;
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_redir = 1'b0;
    end else begin
      mon_acc = bus.o_mem_rd_en && !bus.i_mem_busy;
      mon_ack = bus.i_mem_ack;
      mon_redir = bus.i_redirect;
      mon_addr = bus.o_mem_addr;
      if (prev_hold && !bus.i_redirect) begin
        check("busy_hold_rd_en", bus.o_mem_rd_en, 1);
        check("busy_hold_addr", {bus.o_mem_addr, 2'b00}, {prev_addr, 2'b00});
      end
      if (prev_redir) check("valid_after_redirect", bus.o_instr_valid, 0);
      if (bus.i_redirect) check("no_req_in_redirect", bus.o_mem_rd_en, 0);
      if (mon_acc) begin
        check("single_outstanding", ram_pending && !bus.i_mem_ack, 0);
        check("req_addr", {bus.o_mem_addr, 2'b00}, exp_req_pc);
      end
      if (bus.i_mem_ack && first_ack_chk && !drv_ack_dead && !bus.i_redirect) begin
        check("first_ack_valid", bus.o_instr_valid, byp);
        first_ack_chk = 1'b0;
      end
      if (bus.o_instr_valid && bus.i_instr_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got pc %h with no expected word", bus.o_instr_pc);
        end else begin
          it = exp_q.pop_front();
          check("instr_pc", bus.o_instr_pc, it.pc);
          check("instr_data", bus.o_instr, it.data);
        end
      end
      prev_hold = bus.o_mem_rd_en && bus.i_mem_busy;
      prev_addr = bus.o_mem_addr;
      prev_redir = bus.i_redirect;
    end
  end

  // One clock of stimulus: absorb the previous cycle, then drive the next one.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (mon_ack && ram_pending) begin
      ram_pending = 1'b0;
      ram_drop = 1'b0;
    end
    if (mon_acc) begin
      ram_pending = 1'b1;
      ram_addr = {mon_addr, 2'b00};
      ram_lat = $urandom_range(lat_max, lat_min);
      exp_req_pc += 32'd4;
    end
    if (mon_redir) begin
      if (ram_pending) ram_drop = 1'b1;
      restart(bus.i_redirect_pc);
    end
    refill();
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rd_data = $urandom;
    drv_ack_dead = 1'b0;
    if (ram_pending) begin
      if (ram_lat == 0) begin
        bus.i_mem_ack = 1'b1;
        bus.i_mem_rd_data = mem_word(ram_addr);
        drv_ack_dead = ram_drop;
      end else ram_lat--;
    end else if (spurious_en && $urandom_range(0, 49) == 0) begin
      bus.i_mem_ack = 1'b1;
      drv_ack_dead = 1'b1;
    end
    bus.i_mem_busy = $urandom_range(0, 99) < busy_pct;
    bus.i_instr_ready = $urandom_range(0, 99) < ready_pct;
    bus.i_redirect = $urandom_range(0, 999) < redir_pm;
    bus.i_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hffffffe0 + $urandom_range(0, 31) : $urandom;
  endtask

  task automatic force_redirect(input logic [31:0] pc);
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_mem_ack = 1'b0; bus.i_mem_busy = 1'b0; bus.i_redirect = 1'b0;
    bus.i_redirect_pc = '0; bus.i_mem_rd_data = '0; bus.i_instr_ready = 1'b1;
    ram_pending = 1'b0; ram_drop = 1'b0; drv_ack_dead = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", bus.o_mem_rd_en, 0);
    check("rst_addr", {bus.o_mem_addr, 2'b00}, boot);
    check("rst_valid", bus.o_instr_valid, 0);
    check("rst_instr", bus.o_instr, 0);
    check("rst_instr_pc", bus.o_instr_pc, 0);
    check("tie_be", bus.o_mem_be, 4'hf);
    check("tie_wr_en", bus.o_mem_wr_en, 0);
    check("tie_wr_data", bus.o_mem_wr_data, 0);
    restart(boot);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int snap;
    bit found;
    lat_min = 0; lat_max = 0; busy_pct = 0; ready_pct = 100; redir_pm = 0; spurious_en = 1'b0;
    do_reset();

    // Steady state: one word per cycle after fill.
    repeat (10) cycle();
    snap = pop_cnt;
    repeat (20) cycle();
    check("steady_throughput", pop_cnt - snap, 20);

    // Core stalls: FIFO fills to depth, then reads stop.
    ready_pct = 0;
    repeat (10) cycle();
    check("stall_rd_en_low", bus.o_mem_rd_en, 0);
    check("stall_valid", bus.o_instr_valid, 1);
    ready_pct = 100; busy_pct = 100;
    snap = pop_cnt;
    repeat (6) cycle();
    check("stall_buffered_words", pop_cnt - snap, depth);

    // RAM busy for 3 cycles: request held, PC advances once on acceptance.
    repeat (3) cycle();
    busy_pct = 0;
    repeat (8) cycle();

    // Redirect with the read of 0xf0000008 in flight.
    do_reset();
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (ram_pending && ram_addr == 32'hf0000008 && !bus.i_mem_ack) found = 1'b1;
    end
    check("reach_f0000008_inflight", found, 1);
    force_redirect(32'hf0000100);
    repeat (15) cycle();

    // Address wrap.
    lat_min = 0; lat_max = 0;
    cycle();
    force_redirect(32'hfffffff9);
    repeat (12) cycle();

    // Randomised traffic.
    lat_max = 2; busy_pct = 25; ready_pct = 70; redir_pm = 20; spurious_en = 1'b1;
    snap = pop_cnt;
    repeat (2000) cycle();
    check("random_traffic_flowed", (pop_cnt - snap) > 300, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_imem_fetch.md
# soc_imem_fetch

Instruction prefetch stage sitting directly upstream of the instruction RAM wrapper: it generates sequential word read requests on the RAM's single-port interface, absorbs the RAM's ack/busy handshake, and buffers returned instruction words in a small FIFO presented to the core with a valid/ready handshake. A core redirect (branch, jump, trap) flushes the buffer, discards any in-flight read and restarts fetching at the new PC.

## Interface
- p_boot_addr, 32'hf0000000, first fetch address after reset; bits [1:0] ignored
- p_fifo_pw2, 1, FIFO depth is 2**p_fifo_pw2 words; legal range 1..4
- i_clk  in  1  global clock
- i_rst_n  in  1  reset; synchronous, active-low
- o_mem_addr  out  [31:2]  word address to instruction RAM
- o_mem_rd_en  out  1  read request
- o_mem_be  out  [3:0]  tied 4'hf
- o_mem_wr_en  out  1  tied 0
- o_mem_wr_data  out  32  tied 0
- i_mem_rd_data  in  32  read data, valid when i_mem_ack=1
- i_mem_busy  in  1  RAM cannot accept a request this cycle
- i_mem_ack  in  1  read data returned
- i_redirect  in  1  flush and restart fetch
- i_redirect_pc  in  32  new fetch PC; bits [1:0] ignored
- o_instr_valid  out  1  o_instr/o_instr_pc valid
- o_instr  out  32  instruction word
- o_instr_pc  out  32  byte address of o_instr, bits [1:0]=0
- i_instr_ready  in  1  core accepts the word

## Operation
- Reset (i_rst_n=0 at a clock edge): state FETCH, fetch PC = {p_boot_addr[31:2],2'b00}, FIFO count 0, outstanding 0, drop 0. Registered outputs: o_mem_rd_en=0, o_mem_addr=p_boot_addr[31:2], o_instr_valid=0, o_instr=0, o_instr_pc=0.
- Request accepted in a cycle where o_mem_rd_en=1 and i_mem_busy=0; on acceptance, outstanding=1, fetch PC += 4 (32-bit wrap 32'hfffffffc -> 0).
- At most one request outstanding; a new request may be accepted in the same cycle as the ack for the previous one (full throughput with 1-cycle RAM).
- Issue condition: (count + outstanding - pop) < 2**p_fifo_pw2, where pop = o_instr_valid & i_instr_ready; o_mem_rd_en held stable while i_mem_busy=1.
- Each request carries its PC in a 30-bit tag register; on non-dropped ack, {data, tag PC} is pushed into FIFO.
- FIFO push and pop in the same cycle: count unchanged, data ordering preserved; push into full FIFO cannot occur (credit rule).
- States: FETCH (normal), DROP (redirect occurred with a request outstanding; next ack discarded, then -> FETCH).
- Redirect: FIFO count -> 0 next cycle, fetch PC <- {i_redirect_pc[31:2],2'b00}, o_instr_valid=0 in the following cycle. If outstanding=1 and no ack this cycle -> DROP; if ack arrives in the redirect cycle it is discarded, stay FETCH. The pop in a redirect cycle is still a valid handshake. A request is not issued in the redirect cycle; first request at new PC one cycle later.
- Redirect while in DROP: stays DROP, PC updated.
- Ack with outstanding=0 is a protocol error; ignored.

## Timing
- Redirect at cycle N -> o_mem_rd_en=1 at new PC in N+1 (FETCH, no outstanding) or the cycle after the dropped ack (DROP).
- Request accepted at N, ack at N+1 -> o_instr_valid at N+2 (FIFO path), N+1 with bypass (see Configuration).
- Steady state with ready held 1 and busy 0: one instruction per cycle.
- i_mem_busy stretches latency only; no ack is expected while busy for an unaccepted request.

## Configuration
- IMEM_FETCH_BYPASS_EN defined: when FIFO is empty and a non-dropped ack arrives, {i_mem_rd_data, tag PC} drive o_instr/o_instr_pc combinationally with o_instr_valid=1 the same cycle; if i_instr_ready=1 the word is not pushed, otherwise it is pushed. Reset-cycle outputs remain forced to reset values.
- Undefined: outputs driven only from FIFO head; +1 cycle latency, all core-side outputs registered.

## Test plan
- Reset release, p_boot_addr=32'hf0000000, ready=1, busy=0, 1-cycle RAM -> requests at 0xf0000000,0xf0000004,...; o_instr_pc sequence matches, one word/cycle after fill.
- ready=0 for 10 cycles, p_fifo_pw2=1 -> exactly 2 words buffered, o_mem_rd_en=0 afterwards, no word lost when ready returns.
- Redirect to 32'hf0000100 while request to 0xf0000008 outstanding -> its ack dropped, next o_instr_pc=0xf0000100, no stale word delivered.
- i_mem_busy=1 for 3 cycles -> o_mem_addr/o_mem_rd_en stable, PC advances once on acceptance.
- Fetch PC 32'hfffffffc -> next request address 0, o_instr_pc wraps to 0.
- With IMEM_FETCH_BYPASS_EN, empty FIFO, ack at cycle N -> o_instr_valid=1 at N; without macro -> at N+1.
